ifu_seq_ctrl: RTL and testbench
===============================

IFU_SEQ_CTRL -- requirements
Module: ifu_seq_ctrl

Interface
REQ-001 Parameter CPU_WIDTH, default 32, SHALL set the PC/address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of WAIT cycles before a fetch error.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 pc  in  CPU_WIDTH  SHALL carry the current PC from the PC register.
REQ-006 imem_req_valid  out  1  SHALL signal a fetch request.
REQ-007 imem_req_ready  in  1  SHALL signal that memory accepts the request.
REQ-008 imem_addr  out  CPU_WIDTH  SHALL carry the fetch address.
REQ-009 imem_rsp_valid  in  1  SHALL mark valid response data.
REQ-010 imem_rsp_data  in  32  SHALL carry the fetched instruction.
REQ-011 inst  out  32  SHALL carry the latched instruction to the decoder.
REQ-012 inst_valid  out  1  SHALL mark the execute cycle.
REQ-013 pc_ena  out  1  SHALL act as the write enable of the PC register.
REQ-014 halted  out  1  SHALL indicate that the core is stopped.
REQ-015 fetch_err  out  1  SHALL indicate that a fetch timeout caused the halt.
REQ-016 instret  out  32  SHALL count retired instructions.

Function
REQ-017 The FSM SHALL have four states, IDLE, REQ, WAIT and EXEC, plus HALT.
REQ-018 IDLE SHALL go to REQ unconditionally after one cycle.
REQ-019 In REQ, imem_req_valid SHALL be 1 and imem_addr SHALL equal pc.
  - imem_req_valid and imem_req_ready both 1 -> go to WAIT.
  - Otherwise stay in REQ, holding valid and address stable.
REQ-020 In WAIT, imem_rsp_valid=1 SHALL latch imem_rsp_data into inst and go to EXEC; the response SHALL be accepted no earlier than the cycle after request acceptance.
REQ-021 imem_rsp_valid SHALL be ignored in every state except WAIT.
REQ-022 EXEC SHALL last exactly one cycle with inst_valid=1.
  - Non-ebreak: pc_ena=1, instret increments by 1, next state REQ.
  - inst==32'h00100073 (ebreak): pc_ena=0, instret unchanged, next state HALT.
REQ-023 Minimum fetch-to-retire latency SHALL be 3 cycles (REQ, WAIT, EXEC) when memory responds in the cycle after acceptance.
REQ-024 pc_ena and inst_valid SHALL be 0 in every state except EXEC.
REQ-025 HALT SHALL be absorbing until reset.
  - halted=1 in HALT.
  - No requests issued.
  - instret frozen.
REQ-026 instret SHALL wrap from 32'hFFFFFFFF to 0 without a flag.
REQ-027 inst SHALL hold its value outside the latch cycle.

Reset
REQ-028 While rst=1 the state SHALL become IDLE and all of the following SHALL be 0 on the next edge:
  - outputs: imem_req_valid, inst_valid, pc_ena, halted, fetch_err;
  - inst and instret cleared;
  - timeout counter cleared.
REQ-029 Reset SHALL override every state, including mid-handshake in REQ or WAIT.
  - Any response arriving after reset SHALL be dropped.
  - The first post-reset request SHALL be issued 2 cycles after rst deasserts.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined, the following SHALL apply:
  - An 8-bit-or-wider counter SHALL clear on WAIT entry and increment each WAIT cycle without response.
  - Reaching TIMEOUT_CYCLES SHALL go to HALT with fetch_err=1.
  - fetch_err SHALL stay 1 until reset.
REQ-031 Without FETCH_TIMEOUT_EN, WAIT SHALL wait indefinitely, fetch_err SHALL be tied to 0, and no counter SHALL be synthesized.

Structure
REQ-032 The shared package SHALL hold:
  - the state encoding typedef;
  - the EBREAK encoding constant 32'h00100073;
  - CPU_WIDTH.
REQ-033 The timeout counter SHALL be one sub-module, fetch_timer, instantiated only under FETCH_TIMEOUT_EN; the rest SHALL be flat.

Verification
REQ-034 Ready memory with response one cycle after acceptance, pc=0x80000000, addi inst:
  - req seen at 0x80000000;
  - inst_valid and pc_ena high in the 3rd cycle;
  - instret=1.
REQ-035 imem_req_ready low for 4 cycles: imem_req_valid=1 and imem_addr stable for all 4 cycles, then WAIT; no pc_ena during the stall.
REQ-036 Response 00100073 -> one EXEC cycle with pc_ena=0, then halted=1 permanently; no further imem_req_valid; instret unchanged.
REQ-037 FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no response -> HALT with fetch_err=1 after 8 WAIT cycles; without the macro the block stays in WAIT for 1000 cycles with fetch_err=0.
REQ-038 rst asserted in WAIT, memory responds next cycle -> response dropped, all outputs 0, new request 2 cycles after deassert.
REQ-039 instret preloaded to FFFFFFFF via a forced sequence, one more retire -> instret=0.

Source files
------------

// File: rtl/ifu_seq_ctrl_pkg.sv
// rtl/ifu_seq_ctrl_pkg.sv - shared state encoding and constants for the fetch sequencer
package ifu_seq_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_HALT = 3'd4
    } ifu_state_t;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return inst == EBREAK_INST;
    endfunction

endpackage

// File: rtl/ifu_seq_ctrl_fetch_timer.sv
// rtl/ifu_seq_ctrl_fetch_timer.sv - WAIT-state cycle counter flagging a fetch timeout
module fetch_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires on the increment that would make the count reach TIMEOUT_CYCLES.
    assign o_expired = i_inc && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ifu_seq_ctrl.sv
// rtl/ifu_seq_ctrl.sv - instruction fetch sequencer (IDLE/REQ/WAIT/EXEC/HALT)
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module ifu_seq_ctrl #(
    parameter int CPU_WIDTH      = ifu_seq_ctrl_pkg::CPU_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic                 pc_ena,
    output logic                 halted,
    output logic                 fetch_err,
    output logic [31:0]          instret
);

    import ifu_seq_ctrl_pkg::*;

    ifu_state_t  r_state;
    logic        r_req_valid;
    logic        r_inst_valid;
    logic        r_pc_ena;
    logic        r_halted;
    logic [31:0] r_inst;
    logic [31:0] r_instret;
    logic        w_timeout;

`ifdef FETCH_TIMEOUT_EN
    logic w_wait_entry;
    logic w_wait_idle;
    logic r_fetch_err;

    assign w_wait_entry = (r_state == ST_REQ) && imem_req_ready;
    assign w_wait_idle  = (r_state == ST_WAIT) && !imem_rsp_valid;

    fetch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fetch_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wait_entry),
        .i_inc     (w_wait_idle),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_err <= 1'b0;
        end else if (w_timeout) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign w_timeout = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_pc_ena     <= 1'b0;
            r_halted     <= 1'b0;
            r_inst       <= 32'h0;
            r_instret    <= 32'h0;
        end else begin
            r_inst_valid <= 1'b0;
            r_pc_ena     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_REQ;
                    r_req_valid <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        r_state     <= ST_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state      <= ST_EXEC;
                        r_inst       <= imem_rsp_data;
                        r_inst_valid <= 1'b1;
                        r_pc_ena     <= !is_ebreak(imem_rsp_data);
                    end else if (w_timeout) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // ebreak never retires; the PC stays on it while halted.
                    if (is_ebreak(r_inst)) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_instret   <= r_instret + 32'd1;
                    end
                end
                ST_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_addr      = pc;
    assign inst           = r_inst;
    assign inst_valid     = r_inst_valid;
    assign pc_ena         = r_pc_ena;
    assign halted         = r_halted;
    assign instret        = r_instret;

endmodule

// File: tb/tb_ifu_seq_ctrl.sv
// tb/tb_ifu_seq_ctrl.sv - directed self-checking bench for ifu_seq_ctrl
module tb_ifu_seq_ctrl;

`ifdef FETCH_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        pc_ena;
    logic        halted;
    logic        fetch_err;
    logic [31:0] instret;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifu_seq_ctrl #(
        .CPU_WIDTH      (32),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .pc_ena         (pc_ena),
        .halted         (halted),
        .fetch_err      (fetch_err),
        .instret        (instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        pc             = 32'h8000_0000;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        repeat (2) cyc();

        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc_ena", {31'd0, pc_ena}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_instret", instret, 32'h0);

        // First fetch: addi at 0x80000000, memory answers the cycle after acceptance
        rst = 1'b0;
        chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
        cyc();
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, 32'h8000_0000);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        chk("wait_req_dropped", {31'd0, imem_req_valid}, 32'd0);
        chk("req_rsp_ignored", inst, 32'h0);
        chk("wait_no_inst_valid", {31'd0, inst_valid}, 32'd0);
        imem_req_ready = 1'b0;
        imem_rsp_data  = 32'h0050_0093;
        cyc();
        chk("exec_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("exec_pc_ena", {31'd0, pc_ena}, 32'd1);
        chk("exec_inst", inst, 32'h0050_0093);
        imem_rsp_valid = 1'b0;
        cyc();
        pc = 32'h8000_0004;
        chk("retire_instret", instret, 32'd1);
        chk("retire_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("next_req_addr", imem_addr, 32'h8000_0004);

        // Four-cycle ready stall with stray responses
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_addr, 32'h8000_0004);
            chk("stall_pc_ena", {31'd0, pc_ena}, 32'd0);
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        cyc();
        chk("stall_wait_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("inst_hold", inst, 32'h0050_0093);

        // ebreak: one EXEC without pc_ena, then permanent halt
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0073;
        cyc();
        chk("ebreak_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("ebreak_pc_ena", {31'd0, pc_ena}, 32'd0);
        chk("ebreak_inst", inst, 32'h0010_0073);
        imem_rsp_valid = 1'b0;
        cyc();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("halt_stays", {31'd0, halted}, 32'd1);
            chk("halt_instret", instret, 32'd1);
        end
        chk("halt_no_fetch_err", {31'd0, fetch_err}, 32'd0);

        // Reset while in WAIT, response arrives right after
        imem_rsp_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        cyc();
        chk("rst2_req", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        chk("rstw_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rstw_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rstw_pc_ena", {31'd0, pc_ena}, 32'd0);
        chk("rstw_inst", inst, 32'h0);
        chk("rstw_instret", instret, 32'h0);
        cyc();
        imem_rsp_valid = 1'b0;
        chk("rstw_new_req", {31'd0, imem_req_valid}, 32'd1);
        chk("rstw_rsp_dropped", inst, 32'h0);
        chk("rstw_no_exec", {31'd0, inst_valid}, 32'd0);

        // instret wrap
        force dut.r_instret = 32'hFFFF_FFFF;
        cyc();
        release dut.r_instret;
        chk("preload_instret", instret, 32'hFFFF_FFFF);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        cyc();
        imem_rsp_valid = 1'b0;
        chk("wrap_pc_ena", {31'd0, pc_ena}, 32'd1);
        cyc();
        chk("wrap_instret", instret, 32'h0);

        // WAIT with no response
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (7) cyc();
        chk("to_not_yet_halted", {31'd0, halted}, 32'd0);
        chk("to_not_yet_err", {31'd0, fetch_err}, 32'd0);
        cyc();
        chk("to_halted", {31'd0, halted}, 32'd1);
        chk("to_fetch_err", {31'd0, fetch_err}, 32'd1);
        repeat (3) cyc();
        chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);
        chk("to_no_req", {31'd0, imem_req_valid}, 32'd0);
`else
        repeat (1000) cyc();
        chk("nto_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("nto_halted", {31'd0, halted}, 32'd0);
        chk("nto_no_req", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        cyc();
        imem_rsp_valid = 1'b0;
        chk("nto_late_exec", {31'd0, inst_valid}, 32'd1);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("final_rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("final_rst_halted", {31'd0, halted}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
